lcd_time_frame_writer: RTL

//  Upstream feeder for the LCD display interface. Each refresh pulse starts one frame: snapshot the
//  BCD time, then send a DDRAM-address instruction and the characters "HH:MM:SS", plus " AM"/" PM"
//  in 12h mode. Each byte uses the interface's send_data/ready handshake. Sits between time_view
//  (hh_mm_ss, am_pm) and the LCD interface. Replaces the ad-hoc send sequencing in the top level.

---
 rtl/lcd_time_frame_writer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lcd_time_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_time_frame_writer
// Brief    : Per-refresh frame sequencer: DDRAM address + "HH:MM:SS[ AM|PM]"
//            streamed to the LCD interface over its send_data/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_time_frame_writer #(
  parameter logic [7:0] LINE_ADDR   = 8'h80,
  parameter int         ACK_TIMEOUT = 16,
  parameter bit         SHOW_AMPM   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh,
  input  logic [19:0] hh_mm_ss,
  input  logic        am_pm,
  input  logic        mode12h,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        ins_data,
  output logic        send_data,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RDY  = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [19:0]      snap_time, snap_time_nxt;
  logic             snap_ampm, snap_ampm_nxt;
  logic             snap_12h, snap_12h_nxt;
  logic             pending, pending_nxt;
  logic [3:0]       index, index_nxt;
  logic [CNT_W-1:0] ack_cnt, ack_cnt_nxt;
  logic [7:0]       data_nxt;
  logic             ins_data_nxt, send_data_nxt, busy_nxt, frame_done_nxt, err_nxt;

  logic [7:0]       byte_val;
  logic             byte_ins;
  logic [3:0]       last_index;

  // Character for the current index, always taken from the frame snapshot
  always_comb begin
    byte_ins = 1'b1;
    byte_val = 8'h20;
    case (index)
      4'd0: begin
        byte_val = LINE_ADDR;
        byte_ins = 1'b0;
      end
      4'd1:  byte_val = {4'h3, 2'b00, snap_time[19:18]};
      4'd2:  byte_val = {4'h3, snap_time[17:14]};
      4'd3:  byte_val = 8'h3A;
      4'd4:  byte_val = {4'h3, 1'b0, snap_time[13:11]};
      4'd5:  byte_val = {4'h3, snap_time[10:7]};
      4'd6:  byte_val = 8'h3A;
      4'd7:  byte_val = {4'h3, 1'b0, snap_time[6:4]};
      4'd8:  byte_val = {4'h3, snap_time[3:0]};
      4'd9:  byte_val = 8'h20;
      4'd10: byte_val = snap_ampm ? 8'h50 : 8'h41;
      4'd11: byte_val = 8'h4D;
      default: byte_val = 8'h20;
    endcase
  end

  assign last_index = (SHOW_AMPM && snap_12h) ? 4'd11 : 4'd8;

  always_comb begin
    state_nxt      = state;
    snap_time_nxt  = snap_time;
    snap_ampm_nxt  = snap_ampm;
    snap_12h_nxt   = snap_12h;
    pending_nxt    = pending;
    index_nxt      = index;
    ack_cnt_nxt    = ack_cnt;
    data_nxt       = data;
    ins_data_nxt   = ins_data;
    send_data_nxt  = 1'b0;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    err_nxt        = err;

    // Requests arriving while a frame is active merge into one pending frame
    if (refresh && (state != IDLE))
      pending_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (refresh || pending) begin
          snap_time_nxt = hh_mm_ss;
          snap_ampm_nxt = am_pm;
          snap_12h_nxt  = mode12h;
          pending_nxt   = 1'b0;
          index_nxt     = 4'd0;
          busy_nxt      = 1'b1;
          state_nxt     = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ready) begin
          data_nxt      = byte_val;
          ins_data_nxt  = byte_ins;
          send_data_nxt = 1'b1;
          ack_cnt_nxt   = '0;
          state_nxt     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!ready) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (ready) begin
          if (index == last_index) begin
            frame_done_nxt = 1'b1;
            busy_nxt       = 1'b0;
            state_nxt      = IDLE;
          end else begin
            index_nxt = index + 4'd1;
            state_nxt = WAIT_RDY;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      snap_time  <= '0;
      snap_ampm  <= 1'b0;
      snap_12h   <= 1'b0;
      pending    <= 1'b0;
      index      <= 4'd0;
      ack_cnt    <= '0;
      data       <= 8'h00;
      ins_data   <= 1'b0;
      send_data  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      snap_time  <= snap_time_nxt;
      snap_ampm  <= snap_ampm_nxt;
      snap_12h   <= snap_12h_nxt;
      pending    <= pending_nxt;
      index      <= index_nxt;
      ack_cnt    <= ack_cnt_nxt;
      data       <= data_nxt;
      ins_data   <= ins_data_nxt;
      send_data  <= send_data_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      err        <= err_nxt;
    end
  end

endmodule
`default_nettype wire
